// File: rtl/icache_refill_ctrl.sv
// I-cache line refill controller: one burst read per miss, beats packed into a line-wide return buffer.
// Optional critical-word forwarding is enabled by defining CRIT_WORD_FWD_EN.
module icache_refill_ctrl #(
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_valid,
    input  logic [ADDR_W-1:0]            miss_addr,
    output logic                         miss_ready,
    input  logic                         flush,
    output logic                         rd_req,
    output logic [ADDR_W-1:0]            rd_addr,
    output logic [7:0]                   rd_len,
    input  logic                         rd_ack,
    input  logic                         ret_valid,
    input  logic                         ret_last,
    input  logic [WORD_W-1:0]            ret_data,
    output logic                         rb_we,
    output logic [WORD_W*LINE_WORDS-1:0] rb_line,
    output logic                         refill_done,
`ifdef CRIT_WORD_FWD_EN
    output logic                         fwd_valid,
    output logic [WORD_W-1:0]            fwd_data,
`endif
    output logic                         refill_err
);

    localparam int CW         = $clog2(LINE_WORDS);
    localparam int LINE_BYTES = LINE_WORDS * WORD_W / 8;
    localparam int BYTE_W     = $clog2(WORD_W / 8);
    localparam logic [CW-1:0]     LAST_IDX  = CW'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [ADDR_W-1:0]   base;

    assign rd_addr = base;
    assign rd_len  = 8'(LINE_WORDS - 1);

`ifdef CRIT_WORD_FWD_EN
    logic [CW-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (state == S_IDLE && miss_valid) begin
            idx <= CW'(miss_addr >> BYTE_W);
        end
    end

    // Combinational so the fetch stage sees the critical word in the beat's own cycle.
    assign fwd_valid = (state == S_RECV) && ret_valid && !flush && (cnt == idx);
    assign fwd_data  = ret_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            base        <= '0;
            rb_line     <= '0;
            miss_ready  <= 1'b1;
            rd_req      <= 1'b0;
            rb_we       <= 1'b0;
            refill_done <= 1'b0;
            refill_err  <= 1'b0;
        end else begin
            rb_we       <= 1'b0;
            refill_done <= 1'b0;
            refill_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (miss_valid) begin
                        base       <= miss_addr & BASE_MASK;
                        miss_ready <= 1'b0;
                        rd_req     <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (rd_ack) begin
                        rd_req <= 1'b0;
                        cnt    <= '0;
                        state  <= flush ? S_DRAIN : S_RECV;
                    end else if (flush) begin
                        rd_req     <= 1'b0;
                        miss_ready <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_RECV: begin
                    // A flush wins over any beat in the same cycle; that beat is not stored.
                    if (flush) begin
                        state <= S_DRAIN;
                    end else if (ret_valid) begin
                        rb_line[int'(cnt)*WORD_W +: WORD_W] <= ret_data;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            if (ret_last) begin
                                rb_we       <= 1'b1;
                                refill_done <= 1'b1;
                                state       <= S_DONE;
                            end else begin
                                refill_err <= 1'b1;
                                state      <= S_DRAIN;
                            end
                        end else if (ret_last) begin
                            refill_err <= 1'b1;
                            miss_ready <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (ret_valid && ret_last) begin
                        miss_ready <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_DONE: begin
                    miss_ready <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    miss_ready <= 1'b1;
                    rd_req     <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed table, multi-cycle corner sequences, then random traffic
// compared against a transaction-level reference model. Define CRIT_WORD_FWD_EN to cover forwarding.
module tb_icache_refill_ctrl;

    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int ADDR_W     = 32;
    localparam int LB         = LINE_WORDS * WORD_W / 8;
    localparam int LW         = WORD_W * LINE_WORDS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              miss_valid = 1'b0;
    logic [ADDR_W-1:0] miss_addr = '0;
    logic              miss_ready;
    logic              flush = 1'b0;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack = 1'b0;
    logic              ret_valid = 1'b0;
    logic              ret_last = 1'b0;
    logic [WORD_W-1:0] ret_data = '0;
    logic              rb_we;
    logic [LW-1:0]     rb_line;
    logic              refill_done;
    logic              refill_err;
`ifdef CRIT_WORD_FWD_EN
    logic              fwd_valid;
    logic [WORD_W-1:0] fwd_data;
`endif

    icache_refill_ctrl #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .flush(flush),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .rb_we(rb_we), .rb_line(rb_line), .refill_done(refill_done),
`ifdef CRIT_WORD_FWD_EN
        .fwd_valid(fwd_valid), .fwd_data(fwd_data),
`endif
        .refill_err(refill_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    // Reference model: refill phase, beats received so far, and the line as an array of words.
    int                phase;   // 0 idle, 1 request, 2 receive, 3 drain, 4 line complete
    int                beats;
    int                crit;
    logic [ADDR_W-1:0] m_base;
    logic [WORD_W-1:0] m_line [LINE_WORDS];
    logic              m_err;

    function automatic logic [LW-1:0] model_line();
        logic [LW-1:0] v = '0;
        for (int i = 0; i < LINE_WORDS; i++) v[i*WORD_W +: WORD_W] = m_line[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs packed as {miss_ready, rd_req, rb_we, refill_done, refill_err}.
    task automatic check_ctl(input string name, input logic r, input logic q, input logic w, input logic e);
        check(name, LW'({miss_ready, rd_req, rb_we, refill_done, refill_err}), LW'({r, q, w, w, e}));
    endtask

    task automatic model_step();
        m_err = 1'b0;
        if (rst) begin
            phase = 0;
            beats = 0;
            for (int i = 0; i < LINE_WORDS; i++) m_line[i] = '0;
        end else begin
            case (phase)
                0: if (miss_valid) begin
                    m_base = miss_addr - (miss_addr % LB);
                    crit   = int'((miss_addr % LB) / (WORD_W / 8));
                    phase  = 1;
                end
                1: if (rd_ack) begin
                    beats = 0;
                    phase = flush ? 3 : 2;
                end else if (flush) begin
                    phase = 0;
                end
                2: if (flush) begin
                    phase = 3;
                end else if (ret_valid) begin
                    m_line[beats] = ret_data;
                    beats++;
                    if (beats == LINE_WORDS) begin
                        phase = ret_last ? 4 : 3;
                        m_err = !ret_last;
                    end else if (ret_last) begin
                        m_err = 1'b1;
                        phase = 0;
                    end
                end
                3: if (ret_valid && ret_last) phase = 0;
                default: phase = 0;
            endcase
        end
    endtask

    // Inputs are set just after an edge; combinational outputs are checked mid-cycle, registered after the edge.
    task automatic tick();
        #1;
`ifdef CRIT_WORD_FWD_EN
        check("fwd_valid", LW'(fwd_valid), LW'(phase == 2 && ret_valid && !flush && beats == crit));
        if (phase == 2 && ret_valid && !flush && beats == crit) check("fwd_data", LW'(fwd_data), LW'(ret_data));
`endif
        @(posedge clk);
        model_step();
        #1;
        if (rb_we) we_count++;
    endtask

    task automatic set_in(input logic mv, input logic [ADDR_W-1:0] ma, input logic fl, input logic ack,
                          input logic rv, input logic rl, input logic [WORD_W-1:0] rd);
        miss_valid = mv; miss_addr = ma; flush = fl; rd_ack = ack;
        ret_valid = rv; ret_last = rl; ret_data = rd;
    endtask

    task automatic idle_in();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    typedef struct {
        logic              mv;
        logic [ADDR_W-1:0] ma;
        logic              ack;
        logic              rv;
        logic              rl;
        logic [WORD_W-1:0] rd;
        logic              e_ready;
        logic              e_req;
        logic              e_we;
        logic              e_err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b1, 32'h1C00_0014, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_ctl("reset_ctl", 1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_line", rb_line, '0);
        check("rd_len", LW'(rd_len), LW'(LINE_WORDS - 1));

        // Normal refill from the vector table
        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].mv, vecs[i].ma, 1'b0, vecs[i].ack, vecs[i].rv, vecs[i].rl, vecs[i].rd);
            tick();
            check_ctl($sformatf("vec%0d_ctl", i), vecs[i].e_ready, vecs[i].e_req, vecs[i].e_we, vecs[i].e_err);
            if (i == 0) check("vec_rd_addr", LW'(rd_addr), LW'(32'h1C00_0010));
        end
        check("vec_line", rb_line, LW'(128'h000000A3_000000A2_000000A1_000000A0));

        // Delayed ack, then flush before ack: request held stable, then drop to idle
        we_count = 0;
        set_in(1'b1, 32'h3000_004C, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        idle_in();
        for (int c = 0; c < 3; c++) begin
            tick();
            check_ctl($sformatf("wait%0d_ctl", c), 1'b0, 1'b1, 1'b0, 1'b0);
            check($sformatf("wait%0d_addr", c), LW'(rd_addr), LW'(32'h3000_0040));
        end
        flush = 1'b1;
        tick();
        check_ctl("req_flush_ctl", 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        check_ctl("stray_ack_ctl", 1'b1, 1'b0, 1'b0, 1'b0);
        idle_in();

        // Flush after the 2nd beat: remaining beats drained, old upper words kept
        set_in(1'b1, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
        set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);            tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB0);        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB1);        tick();
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);            tick();
        check_ctl("flush_drain_ctl", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB2);        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB3);        tick();
        check_ctl("flush_idle_ctl", 1'b1, 1'b0, 1'b0, 1'b0);
        check("flush_line", rb_line, LW'(128'h000000A3_000000A2_000000B1_000000B0));
        check("flush_no_we", LW'(we_count), '0);
        idle_in();

        // Short burst: last on 2nd beat
        set_in(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
        set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);            tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC0);        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC1);        tick();
        check_ctl("short_err_ctl", 1'b1, 1'b0, 1'b0, 1'b1);
        idle_in(); tick();
        check_ctl("short_after_ctl", 1'b1, 1'b0, 1'b0, 1'b0);

        // Long burst: four beats without last, then drain
        set_in(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
        set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);            tick();
        for (int b = 0; b < LINE_WORDS; b++) begin
            set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, WORD_W'(32'hD0 + b)); tick();
        end
        check_ctl("long_err_ctl", 1'b0, 1'b0, 1'b0, 1'b1);
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hD4);        tick();
        check_ctl("long_drain_ctl", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD5);        tick();
        check_ctl("long_idle_ctl", 1'b1, 1'b0, 1'b0, 1'b0);
        check("short_long_no_we", LW'(we_count), '0);

        // Reset mid-receive, then a clean refill
        set_in(1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
        set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);            tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hE0);        tick();
        idle_in(); rst = 1'b1; tick(); rst = 1'b0;
        check_ctl("rst_mid_ctl", 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_mid_line", rb_line, '0);
        set_in(1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
        check("rst_new_addr", LW'(rd_addr), LW'(32'h0000_1230));
        set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);            tick();
        for (int b = 0; b < LINE_WORDS; b++) begin
            set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, b == LINE_WORDS - 1, WORD_W'(32'hF0 + b)); tick();
        end
        check_ctl("rst_new_done_ctl", 1'b0, 1'b0, 1'b1, 1'b0);
        idle_in(); tick();
        check_ctl("rst_new_idle_ctl", 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_new_line", rb_line, LW'(128'h000000F3_000000F2_000000F1_000000F0));

`ifdef CRIT_WORD_FWD_EN
        // Critical word 2 is forwarded on the 3rd beat only; a flush before it suppresses forwarding
        set_in(1'b1, 32'h0000_0408, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
        set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);            tick();
        for (int b = 0; b < LINE_WORDS; b++) begin
            set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, b == LINE_WORDS - 1, WORD_W'(32'h50 + b));
            #1;
            check($sformatf("fwd_beat%0d", b), LW'({fwd_valid, fwd_data}), LW'({b == 2, WORD_W'(32'h50 + b)}));
            tick();
        end
        idle_in(); tick();
        set_in(1'b1, 32'h0000_0508, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
        set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);            tick();
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);            tick();
        for (int b = 0; b < LINE_WORDS; b++) begin
            set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, b == LINE_WORDS - 1, WORD_W'(32'h60 + b));
            #1;
            check($sformatf("fwd_flushed%0d", b), LW'(fwd_valid), '0);
            tick();
        end
        idle_in(); tick();
`endif

        // Random traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            miss_valid = ($urandom_range(0, 1) == 1);
            miss_addr  = $urandom & 32'hFFFF_FFFC;
            rd_ack     = ($urandom_range(0, 4) < 2);
            flush      = ($urandom_range(0, 15) == 0);
            ret_valid  = ($urandom_range(0, 9) < 6);
            ret_data   = $urandom;
            if (phase == 2 && beats == LINE_WORDS - 1)
                ret_last = ret_valid && ($urandom_range(0, 5) != 0);
            else
                ret_last = ret_valid && ($urandom_range(0, 7) == 0);
            tick();
            check("rnd_ctl", LW'({miss_ready, rd_req, rb_we, refill_done, refill_err}),
                  LW'({phase == 0, phase == 1, phase == 4, phase == 4, m_err}));
            check("rnd_line", rb_line, model_line());
            if (phase == 1) check("rnd_rd_addr", LW'(rd_addr), LW'(m_base));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
